memory_dp: RTL and testbench



---
 rtl/memory_dp_pkg.sv | 14 +
 rtl/mem_rd_pipe.sv | 55 +++++
 rtl/memory_dp.sv | 158 +++++++++++++++
 tb/tb_memory_dp.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_dp_pkg.sv
// Shared definitions for the memory_dp dual-port RAM: FSM encoding,
// read-during-write mode constants and the read latency limit.
package memory_dp_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int RW_READ_FIRST    = 0;
    localparam int RW_WRITE_FIRST   = 1;
    localparam int MAX_READ_LATENCY = 2;

endpackage

// File: rtl/mem_rd_pipe.sv
// Valid/data delay line placed after the first read register of a port.
// Data in each stage only moves with its valid, so the output holds the
// last delivered word while no response is in flight.
module mem_rd_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Zero-length line: clock and reset are intentionally unused.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;
            assign o_valid          = i_valid;
            assign o_data           = i_data;
        end else begin : g_pipe
            logic [DEPTH-1:0]      r_valid;
            logic [DATA_WIDTH-1:0] r_data [DEPTH];

            // Shift valids every cycle; advance data only alongside a valid.
            // NOTE: non-blocking assignments here let every stage sample the
            // previous stage's old value, which is what makes this a shift.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        r_data[i] <= '0;
                    end
                end else begin
                    r_valid[0] <= i_valid;
                    if (i_valid) begin
                        r_data[0] <= i_data;
                    end
                    for (int i = 1; i < DEPTH; i++) begin
                        r_valid[i] <= r_valid[i-1];
                        if (r_valid[i-1]) begin
                            r_data[i] <= r_data[i-1];
                        end
                    end
                end
            end

            assign o_valid = r_valid[DEPTH-1];
            assign o_data  = r_data[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/memory_dp.sv
// Synchronous dual-port RAM: port A read/write, port B read-only.
// Request/valid handshakes, 1- or 2-cycle read latency, selectable
// read-during-write behaviour and an optional post-reset clear sequencer.
module memory_dp
    import memory_dp_pkg::*;
#(
    parameter string FILE_NAME      = "mem_init.mif",
    parameter int    ADDR_WIDTH     = 6,
    parameter int    DATA_WIDTH     = 16,
    parameter int    READ_LATENCY   = 1,
    parameter int    RW_MODE        = 0,
    parameter int    CLEAR_ON_RESET = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic                  a_valid,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  b_valid,
    output logic                  busy
);

    localparam int                    DEPTH       = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
    localparam bit                    WRITE_FIRST = (RW_MODE == RW_WRITE_FIRST);
    localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
            $error("memory_dp: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    (* ram_init_file = FILE_NAME *)
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_next;

    logic                  w_busy;
    logic                  w_a_acc;
    logic                  w_a_wr;
    logic                  w_b_acc;
    logic                  w_clr_we;
    logic [DATA_WIDTH-1:0] w_a_rd_data;
    logic [DATA_WIDTH-1:0] w_b_rd_data;

    logic                  r_a_v1;
    logic                  r_b_v1;
    logic [DATA_WIDTH-1:0] r_a_d1;
    logic [DATA_WIDTH-1:0] r_b_d1;

    // Reset dominates: nothing is accepted on an edge where rst is high.
    assign w_busy   = (r_state == ST_CLEAR);
    assign w_a_acc  = a_req & ~w_busy & ~rst;
    assign w_b_acc  = b_req & ~w_busy & ~rst;
    assign w_a_wr   = w_a_acc & a_we;
    assign w_clr_we = w_busy & ~rst;
    assign busy     = w_busy;

    // Read-during-write: the array read returns the pre-edge word (read-first);
    // write-first bypasses the incoming write data, also for a B collision.
    assign w_a_rd_data = (w_a_wr && WRITE_FIRST) ? a_data : r_mem[a_addr];
    assign w_b_rd_data = (w_a_wr && WRITE_FIRST && (a_addr == b_addr)) ? a_data : r_mem[b_addr];

    // Clear FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RESET_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Clear FSM next state: walk every address once, then run.
    // NOTE: every output of this block is assigned a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            ST_CLEAR: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end
            end
            ST_RUN:   w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    // Array write port, shared by the clear sequencer and port A.
    // NOTE: the array has no reset branch; contents survive reset and only the
    // clear sequencer zeroes them, which keeps it mappable to block RAM.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_a_wr) begin
            r_mem[a_addr] <= a_data;
        end
    end

    // First read stage of both ports; data registers hold between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_v1 <= 1'b0;
            r_b_v1 <= 1'b0;
            r_a_d1 <= '0;
            r_b_d1 <= '0;
        end else begin
            r_a_v1 <= w_a_acc;
            r_b_v1 <= w_b_acc;
            if (w_a_acc) begin
                r_a_d1 <= w_a_rd_data;
            end
            if (w_b_acc) begin
                r_b_d1 <= w_b_rd_data;
            end
        end
    end

    mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (READ_LATENCY - 1)
    ) u_a_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_a_v1),
        .i_data  (r_a_d1),
        .o_valid (a_valid),
        .o_data  (a_out)
    );

    mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (READ_LATENCY - 1)
    ) u_b_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_b_v1),
        .i_data  (r_b_d1),
        .o_valid (b_valid),
        .o_data  (b_out)
    );

endmodule

// File: tb/tb_memory_dp.sv
// Scoreboard bench for memory_dp. Three instances cover the configurations:
//   dut0: READ_LATENCY=1, read-first,  no clear
//   dut1: READ_LATENCY=2, write-first, no clear
//   dut2: READ_LATENCY=1, read-first,  clear on reset
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_memory_dp;

    typedef struct {
        int          dut;
        int          port;
        int          due;
        bit          chk;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst     [3];
    logic        a_req   [3];
    logic        a_we    [3];
    logic [5:0]  a_addr  [3];
    logic [15:0] a_data  [3];
    logic [15:0] a_out   [3];
    logic        a_valid [3];
    logic        b_req   [3];
    logic [5:0]  b_addr  [3];
    logic [15:0] b_out   [3];
    logic        b_valid [3];
    logic        busy    [3];

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        memory_dp #(
            .ADDR_WIDTH     (6),
            .DATA_WIDTH     (16),
            .READ_LATENCY   ((k == 1) ? 2 : 1),
            .RW_MODE        ((k == 1) ? 1 : 0),
            .CLEAR_ON_RESET ((k == 2) ? 1 : 0)
        ) u_dut (
            .clk     (clk),
            .rst     (rst[k]),
            .a_req   (a_req[k]),
            .a_we    (a_we[k]),
            .a_addr  (a_addr[k]),
            .a_data  (a_data[k]),
            .a_out   (a_out[k]),
            .a_valid (a_valid[k]),
            .b_req   (b_req[k]),
            .b_addr  (b_addr[k]),
            .b_out   (b_out[k]),
            .b_valid (b_valid[k]),
            .busy    (busy[k])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expectation for this dut/port and compare time and data.
    task automatic score(input int k, input int p, input logic [15:0] d);
        int    idx = -1;
        string nm  = $sformatf("dut%0d.%s", k, (p == 0) ? "a" : "b");
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].dut == k && sb[i].port == p) begin
                idx = i;
                break;
            end
        end
        if (idx < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s unexpected valid: got data %h at cycle %0d, required no response", nm, d, cyc);
        end else begin
            check({nm, " valid cycle"}, cyc, sb[idx].due);
            if (sb[idx].chk) check({nm, " data"}, d, sb[idx].data);
            sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (a_valid[k] === 1'b1) score(k, 0, a_out[k]);
            if (b_valid[k] === 1'b1) score(k, 1, b_out[k]);
        end
    end

    // One cycle of requests on dut k; drop=1 means no response is expected.
    task automatic op(input int k, input bit drop,
                      input bit a_en, input bit we, input logic [5:0] aa, input logic [15:0] ad,
                      input bit a_chk, input logic [15:0] a_exp,
                      input bit b_en, input logic [5:0] ba, input logic [15:0] b_exp);
        a_req[k]  = a_en;
        a_we[k]   = we;
        a_addr[k] = aa;
        a_data[k] = ad;
        b_req[k]  = b_en;
        b_addr[k] = ba;
        if (!drop && a_en) sb.push_back('{dut: k, port: 0, due: cyc + lat_of(k), chk: a_chk, data: a_exp});
        if (!drop && b_en) sb.push_back('{dut: k, port: 1, due: cyc + lat_of(k), chk: 1'b1, data: b_exp});
        tick();
        a_req[k] = 1'b0;
        a_we[k]  = 1'b0;
        b_req[k] = 1'b0;
    endtask

    task automatic wr(input int k, input logic [5:0] aa, input logic [15:0] ad,
                      input bit chk, input logic [15:0] exp);
        op(k, 1'b0, 1'b1, 1'b1, aa, ad, chk, exp, 1'b0, 6'd0, 16'h0);
    endtask

    task automatic rd_a(input int k, input logic [5:0] aa, input logic [15:0] exp);
        op(k, 1'b0, 1'b1, 1'b0, aa, 16'h0, 1'b1, exp, 1'b0, 6'd0, 16'h0);
    endtask

    task automatic rd_b(input int k, input logic [5:0] ba, input logic [15:0] exp);
        op(k, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 16'h0, 1'b1, ba, exp);
    endtask

    task automatic pulse_rst(input int k);
        rst[k] = 1'b1;
        tick();
        rst[k] = 1'b0;
    endtask

    // Count busy cycles of dut2; optionally poke a write+read while busy.
    task automatic run_clear(input string name, input int poke_at);
        int n = 0;
        while (busy[2] === 1'b1 && n < 200) begin
            n++;
            if (n == poke_at) op(2, 1'b1, 1'b1, 1'b1, 6'd3, 16'hDEAD, 1'b0, 16'h0, 1'b1, 6'd3, 16'h0);
            else tick();
        end
        check(name, n, 64);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]    = 1'b1;
            a_req[k]  = 1'b0;
            a_we[k]   = 1'b0;
            a_addr[k] = '0;
            a_data[k] = '0;
            b_req[k]  = 1'b0;
            b_addr[k] = '0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // Reset state of every instance.
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d reset a_valid", k), a_valid[k], 0);
            check($sformatf("dut%0d reset b_valid", k), b_valid[k], 0);
            check($sformatf("dut%0d reset a_out", k), a_out[k], 0);
            check($sformatf("dut%0d reset b_out", k), b_out[k], 0);
            check($sformatf("dut%0d reset busy", k), busy[k], (k == 2) ? 1 : 0);
        end
        run_clear("dut2 power-up clear length", -1);

        // Latency 1: write then read back on A and B; outputs hold afterwards.
        wr(0, 6'd8, 16'h7101, 1'b0, 16'h0);
        rd_a(0, 6'd8, 16'h7101);
        rd_b(0, 6'd8, 16'h7101);
        tick();
        tick();
        check("dut0 a_out hold", a_out[0], 16'h7101);
        check("dut0 b_out hold", b_out[0], 16'h7101);
        wr(0, 6'd9, 16'h8101, 1'b0, 16'h0);
        wr(0, 6'd10, 16'h0210, 1'b0, 16'h0);
        wr(0, 6'd5, 16'h1234, 1'b0, 16'h0);
        rd_a(0, 6'd8, 16'h7101);
        rd_a(0, 6'd9, 16'h8101);
        rd_a(0, 6'd10, 16'h0210);
        // Read-first collision: both ports see the old word.
        op(0, 1'b0, 1'b1, 1'b1, 6'd5, 16'hBEEF, 1'b1, 16'h1234, 1'b1, 6'd5, 16'h1234);
        rd_a(0, 6'd5, 16'hBEEF);
        tick();
        tick();

        // Latency 2, write-first: write responses return the new word.
        wr(1, 6'd8, 16'h7101, 1'b1, 16'h7101);
        wr(1, 6'd9, 16'h8101, 1'b1, 16'h8101);
        wr(1, 6'd10, 16'h0210, 1'b1, 16'h0210);
        wr(1, 6'd5, 16'h1234, 1'b1, 16'h1234);
        rd_a(1, 6'd8, 16'h7101);
        rd_a(1, 6'd9, 16'h8101);
        rd_a(1, 6'd10, 16'h0210);
        // Write-first collision: both ports see the new word.
        op(1, 1'b0, 1'b1, 1'b1, 6'd5, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 6'd5, 16'hBEEF);
        // Different addresses: B must not pick up the A write data.
        op(1, 1'b0, 1'b1, 1'b1, 6'd9, 16'h5A5A, 1'b1, 16'h5A5A, 1'b1, 6'd8, 16'h7101);
        rd_a(1, 6'd9, 16'h5A5A);
        rd_b(1, 6'd5, 16'hBEEF);
        tick();
        tick();
        tick();

        // Reset with responses in flight: they must never appear.
        op(1, 1'b1, 1'b1, 1'b0, 6'd8, 16'h0, 1'b0, 16'h0, 1'b1, 6'd10, 16'h0);
        pulse_rst(1);
        check("dut1 flush a_valid", a_valid[1], 0);
        check("dut1 flush b_valid", b_valid[1], 0);
        check("dut1 flush a_out", a_out[1], 0);
        check("dut1 flush b_out", b_out[1], 0);
        tick();
        tick();
        tick();
        rd_a(1, 6'd8, 16'h7101);
        tick();
        tick();

        // Clear on reset: preload, pulse reset, poke during busy, read zeros.
        for (int a = 0; a < 64; a++) wr(2, 6'(a), 16'hA500 | 16'(a), 1'b1, 16'h0);
        rd_a(2, 6'd0, 16'hA500);
        rd_b(2, 6'd63, 16'hA53F);
        tick();
        pulse_rst(2);
        check("dut2 reset a_out", a_out[2], 0);
        check("dut2 reset b_out", b_out[2], 0);
        run_clear("dut2 clear length", 10);
        for (int a = 0; a < 64; a++)
            op(2, 1'b0, 1'b1, 1'b0, 6'(a), 16'h0, 1'b1, 16'h0, 1'b1, 6'(63 - a), 16'h0);
        tick();

        // Reset at clear cycle 30 restarts the full clear.
        for (int a = 0; a < 64; a++) wr(2, 6'(a), 16'hC000 | 16'(a), 1'b1, 16'h0);
        pulse_rst(2);
        repeat (30) tick();
        check("dut2 busy at clear cycle 30", busy[2], 1);
        pulse_rst(2);
        run_clear("dut2 restarted clear length", -1);
        for (int a = 0; a < 64; a++)
            op(2, 1'b0, 1'b1, 1'b0, 6'(a), 16'h0, 1'b1, 16'h0, 1'b1, 6'(a), 16'h0);

        repeat (4) tick();
        check("scoreboard entries left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
